cp0_irq_ctrl: RTL
=================

// Module: cp0_irq_ctrl
// PURPOSE
//  Coprocessor-0 interrupt/exception receiver for the P7 pipelined MIPS core.
//  Sinks the IRQ lines of bus devices (timers, external) as HWInt[7:2].
//  Applies the SR mask, makes the take-exception decision for the M stage,
//  latches Cause/EPC, and services mfc0/mtc0/eret.
//  Sits beside the M stage. The core flushes and redirects to HANDLER_PC when exc_take=1.
// PARAMETERS
//  PRID        32'h0712_2017  read-only value returned for CP0 reg 15
//  HANDLER_PC  32'h0000_4180  exception vector driven on handler_pc
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   synchronous, active-high
//  cp0_addr    in   5   CP0 register number (rd field of mfc0/mtc0)
//  cp0_we      in   1   mtc0 write strobe (M stage)
//  cp0_wdata   in   32  mtc0 write data
//  cp0_rdata   out  32  mfc0 read data, combinational from cp0_addr
//  pc_m        in   32  PC of the instruction currently in M
//  bd_m        in   1   instruction in M is in a branch delay slot
//  exc_valid   in   1   synchronous exception pending for the M instruction
//  exc_code    in   5   ExcCode for that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov)
//  hw_int      in   6   device IRQ lines (bit0 = Timer0, bit1 = Timer1, bit2 = external)
//  eret        in   1   eret in M stage
//  exc_take    out  1   take exception/interrupt this cycle (combinational)
//  epc_out     out  32  current EPC, used as the eret target
//  handler_pc  out  32  constant HANDLER_PC
// BEHAVIOUR
//  Registers:
//   SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
//   Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
//   EPC(14): 32 bits, word-aligned.
//   PRId(15): PRID. Any other addr reads 32'h0.
//  Reset: IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0.
//   Hence exc_take=0 and epc_out=0 after reset.
//  IP[15:10] <= hw_int every cycle, including reset release.
//   IP is the registered copy, readable by mfc0 one cycle after the line changes.
//  int_req = |(hw_int & IM) & IE & ~EXL. This uses the raw hw_int, not IP, so there is zero added latency.
//  exc_req = exc_valid & ~EXL.
//  exc_take = int_req | exc_req.
//  Priority: interrupt over synchronous exception.
//   When both are true, ExcCode=0 and EPC is taken from the M instruction.
//  On posedge with exc_take=1:
//   - EXL<=1.
//   - BD<=bd_m.
//   - ExcCode <= int_req ? 5'd0 : exc_code.
//   - EPC <= bd_m ? {pc_m[31:2],2'b00}-4 : {pc_m[31:2],2'b00}.
//  mtc0 (cp0_we=1, exc_take=0):
//   - addr 12 writes IM/EXL/IE.
//   - addr 14 writes EPC with {wdata[31:2],2'b00}.
//   - addr 13 and addr 15 are read-only; the write is ignored.
//  Simultaneous exc_take and cp0_we: exc_take wins and the mtc0 is discarded.
//  eret (exc_take=0): EXL<=0 on posedge.
//   An interrupt is blocked during the eret cycle because EXL=1.
//   It may fire on the next cycle.
//  While EXL=1:
//   - All interrupts are masked.
//   - exc_valid is ignored: no nesting, EPC and Cause are not overwritten.
//   - mtc0 still works.
//  mfc0 read of SR/EPC in the same cycle as a mtc0 to it returns the old value.
//   There is no internal bypass; the core forwards.
//  hw_int is level-sensitive and not latched as pending.
//   If a device drops IRQ before IE&IM allow it, nothing is taken.
//  Reset asserted mid-handler (EXL=1) clears everything; no exception is taken that cycle.
// TESTING
//  1. reset; SR=0x0000_0401 (IM0=1, IE=1); raise hw_int[0] with pc_m=0x3010, bd_m=0
//     -> exc_take=1 same cycle; next cycle EPC=0x3010, Cause=0x0000_0400, SR.EXL=1, exc_take=0.
//  2. Hold hw_int[0]=1 and issue eret
//     -> exc_take=0 in the eret cycle; EXL=0 after the edge; exc_take=1 on the following cycle.
//  3. exc_valid=1, exc_code=12, pc_m=0x3024, bd_m=1, IE=0
//     -> EPC=0x3020, Cause=0x8000_0030, EXL=1.
//  4. hw_int[1]=1 with IM1=1, IE=1, and exc_valid=1, exc_code=10 in the same cycle
//     -> ExcCode=0, IP bit 11 set.
//  5. cp0_we to addr 12 with wdata 0x0000_FC01 in the same cycle as exc_take
//     -> SR keeps its old IM; EXL=1.
//  6. mtc0 EPC=0x0000_3007 -> mfc0 14 returns 0x3004;
//     mfc0 15 returns PRID; mfc0 8 returns 0.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_irq_ctrl
//  Description : Coprocessor-0 interrupt/exception receiver for a pipelined
//                MIPS core. Masks device IRQ lines with SR, decides whether
//                the M-stage instruction takes an exception or interrupt,
//                latches Cause/EPC, and services mfc0/mtc0/eret.
//  Ports       :
//    clk, reset           clock; synchronous active-high reset
//    cp0_addr/we/wdata    mtc0 write port (register number from rd field)
//    cp0_rdata            mfc0 read data, combinational from cp0_addr
//    pc_m, bd_m           PC and delay-slot flag of the M-stage instruction
//    exc_valid, exc_code  synchronous exception request and its ExcCode
//    hw_int               device IRQ lines HWInt[7:2]
//    eret                 eret in M stage
//    exc_take             take exception/interrupt this cycle
//    epc_out              current EPC (eret target)
//    handler_pc           constant exception vector
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_irq_ctrl #(
    parameter logic [31:0] PRID       = 32'h0712_2017,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        exc_take,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;
    localparam logic [4:0] c_ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    // EPC
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_pc_aligned;
    logic [31:0] w_epc_next;
    logic        w_unused_pc_bits;

    // Raw hw_int is used (not the registered IP) so an interrupt is seen
    // in the same cycle the line rises.
    assign w_int_req = (|(hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = exc_valid & ~r_exl;
    assign exc_take  = w_int_req | w_exc_req;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign w_pc_aligned = {pc_m[31:2], 2'b00};
    assign w_epc_next   = bd_m ? (w_pc_aligned - 32'd4) : w_pc_aligned;

    assign w_unused_pc_bits = &{1'b0, pc_m[1:0]};

    assign epc_out    = r_epc;
    assign handler_pc = HANDLER_PC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            r_ip <= hw_int;
            if (exc_take) begin
                // Exception entry overrides any mtc0 or eret in the same cycle.
                r_exl     <= 1'b1;
                r_bd      <= bd_m;
                r_exccode <= w_int_req ? 5'd0 : exc_code;
                r_epc     <= w_epc_next;
            end else begin
                if (cp0_we && (cp0_addr == c_ADDR_SR)) begin
                    r_im  <= cp0_wdata[15:10];
                    r_exl <= cp0_wdata[1];
                    r_ie  <= cp0_wdata[0];
                end
                if (cp0_we && (cp0_addr == c_ADDR_EPC)) begin
                    r_epc <= {cp0_wdata[31:2], 2'b00};
                end
                if (eret) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    // No bypass of a same-cycle mtc0: the core forwards around this.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            c_ADDR_SR:    cp0_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
            c_ADDR_CAUSE: cp0_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
            c_ADDR_EPC:   cp0_rdata = r_epc;
            c_ADDR_PRID:  cp0_rdata = PRID;
            default:      cp0_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
